// File: rtl/conv_sched_if.sv
// Signal bundle between the convolution scheduler and the input memory, the MAC lanes and the load controller.
interface conv_sched_if #(
  parameter int R    = 15,
  parameter int C    = 13,
  parameter int MAXK = 7
);
  localparam int K_BITS      = $clog2(MAXK + 1);
  localparam int X_ADDR_BITS = $clog2(R * C);
  localparam int W_ADDR_BITS = $clog2(MAXK * MAXK);

  logic                   inputs_loaded;
  logic [K_BITS-1:0]      K;
  logic                   out_ready;
  logic                   compute_finished;
  logic [X_ADDR_BITS-1:0] X_read_addr_0;
  logic [X_ADDR_BITS-1:0] X_read_addr_1;
  logic [X_ADDR_BITS-1:0] X_read_addr_2;
  logic [X_ADDR_BITS-1:0] X_read_addr_3;
  logic [W_ADDR_BITS-1:0] W_read_addr_0;
  logic [W_ADDR_BITS-1:0] W_read_addr_1;
  logic [W_ADDR_BITS-1:0] W_read_addr_2;
  logic [W_ADDR_BITS-1:0] W_read_addr_3;
  logic                   mac_en;
  logic                   mac_first;
  logic                   mac_last;
  logic [3:0]             lane_valid;

  modport master (
    input  inputs_loaded, K, out_ready,
    output compute_finished,
    output X_read_addr_0, X_read_addr_1, X_read_addr_2, X_read_addr_3,
    output W_read_addr_0, W_read_addr_1, W_read_addr_2, W_read_addr_3,
    output mac_en, mac_first, mac_last, lane_valid
  );

  modport slave (
    output inputs_loaded, K, out_ready,
    input  compute_finished,
    input  X_read_addr_0, X_read_addr_1, X_read_addr_2, X_read_addr_3,
    input  W_read_addr_0, W_read_addr_1, W_read_addr_2, W_read_addr_3,
    input  mac_en, mac_first, mac_last, lane_valid
  );
endinterface

// File: rtl/conv_sched.sv
// Convolution compute scheduler: walks output positions four at a time, issues
// X/W read addresses every cycle and emits MAC strobes aligned to the read data.
module conv_sched #(
  parameter int R    = 15,
  parameter int C    = 13,
  parameter int MAXK = 7
) (
  input  logic         clk,
  input  logic         reset,
  conv_sched_if.master bus
);
  localparam int KB = $clog2(MAXK + 1);
  localparam int XW = $clog2(R * C);
  localparam int WW = $clog2(MAXK * MAXK);
  localparam int NW = XW + 1;
  localparam int CW = $clog2(C + 1);
  localparam int RW = $clog2(R + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_DRAIN, S_DONE} state_e;

  // A lane position: output column plus the matching top-left X address.
  typedef struct packed {
    logic [CW-1:0] col;
    logic [XW-1:0] base;
  } pos_t;

  // One row-major step over the OR x OC output grid; wrapping a row skips K-1 input columns.
  function automatic pos_t step(input pos_t p, input logic [CW-1:0] oc, input logic [KB-1:0] k);
    pos_t          r;
    logic [CW-1:0] nc;
    nc = p.col + CW'(1);
    if (nc == oc) begin
      r.col  = '0;
      r.base = p.base + XW'(k);
    end else begin
      r.col  = nc;
      r.base = p.base + XW'(1);
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic            armed_q, armed_d;
  logic [KB-1:0]   k_q, k_d;
  logic [CW-1:0]   oc_q, oc_d;
  logic [NW-1:0]   n_q, n_d;
  logic [NW-1:0]   grp_q, grp_d;
  logic [WW-1:0]   t_q, t_d;
  logic [WW-1:0]   tmax_q, tmax_d;
  logic [KB-1:0]   wc_q, wc_d;
  logic [XW-1:0]   toff_q, toff_d;
  pos_t [3:0]      pos_q, pos_d;
  logic            mac_en_q, mac_first_q, mac_last_q;
  logic [3:0]      lane_valid_q;

  logic            issue, last_tap, last_grp, k_ok;
  logic [3:0]      lane_ok;
  logic [CW-1:0]   oc_s;
  logic [RW-1:0]   or_s;
  logic [WW-1:0]   tmax_s;

  assign k_ok     = (bus.K != '0) && (int'(bus.K) <= R) && (int'(bus.K) <= C);
  assign oc_s     = CW'(C) - CW'(bus.K) + CW'(1);
  assign or_s     = RW'(R) - RW'(bus.K) + RW'(1);
  assign tmax_s   = WW'(bus.K) * WW'(bus.K) - WW'(1);
  assign last_tap = (t_q == tmax_q);
  assign last_grp = (grp_q + NW'(4)) >= n_q;
  // A group may only start with downstream room; once started it runs to its last tap.
  assign issue    = (state_q == S_ISSUE) && ((t_q != '0) || bus.out_ready);

  always_comb begin
    lane_ok = '0;
    for (int i = 0; i < 4; i++) lane_ok[i] = (grp_q + NW'(i)) < n_q;
  end

  // NOTE: every next-state variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    pos_t p;
    state_d = state_q;
    armed_d = armed_q;
    k_d     = k_q;
    oc_d    = oc_q;
    n_d     = n_q;
    grp_d   = grp_q;
    t_d     = t_q;
    tmax_d  = tmax_q;
    wc_d    = wc_q;
    toff_d  = toff_q;
    pos_d   = pos_q;
    p       = '0;
    case (state_q)
      S_IDLE: begin
        if (!bus.inputs_loaded) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        k_d    = bus.K;
        oc_d   = oc_s;
        n_d    = NW'(or_s) * NW'(oc_s);
        tmax_d = tmax_s;
        grp_d  = '0;
        t_d    = '0;
        wc_d   = '0;
        toff_d = '0;
        for (int i = 0; i < 4; i++) begin
          pos_d[i] = p;
          p = step(p, oc_s, bus.K);
        end
        state_d = k_ok ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        if (issue) begin
          if (last_tap) begin
            t_d    = '0;
            wc_d   = '0;
            toff_d = '0;
            if (last_grp) begin
              state_d = S_DRAIN;
            end else begin
              grp_d = grp_q + NW'(4);
              for (int i = 0; i < 4; i++) begin
                p = pos_q[i];
                for (int j = 0; j < 4; j++) p = step(p, oc_q, k_q);
                pos_d[i] = p;
              end
            end
          end else begin
            t_d = t_q + WW'(1);
            if (wc_q == k_q - KB'(1)) begin
              wc_d   = '0;
              toff_d = toff_q + XW'(oc_q);
            end else begin
              wc_d   = wc_q + KB'(1);
              toff_d = toff_q + XW'(1);
            end
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset clears every register, including the lane position array; it is only four entries, not a memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b1;
      k_q          <= '0;
      oc_q         <= '0;
      n_q          <= '0;
      grp_q        <= '0;
      t_q          <= '0;
      tmax_q       <= '0;
      wc_q         <= '0;
      toff_q       <= '0;
      pos_q        <= '0;
      mac_en_q     <= 1'b0;
      mac_first_q  <= 1'b0;
      mac_last_q   <= 1'b0;
      lane_valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      armed_q      <= armed_d;
      k_q          <= k_d;
      oc_q         <= oc_d;
      n_q          <= n_d;
      grp_q        <= grp_d;
      t_q          <= t_d;
      tmax_q       <= tmax_d;
      wc_q         <= wc_d;
      toff_q       <= toff_d;
      pos_q        <= pos_d;
      mac_en_q     <= issue;
      mac_first_q  <= issue && (t_q == '0);
      mac_last_q   <= issue && last_tap;
      lane_valid_q <= issue ? lane_ok : 4'b0000;
    end
  end

  assign bus.X_read_addr_0    = (issue && lane_ok[0]) ? pos_q[0].base + toff_q : '0;
  assign bus.X_read_addr_1    = (issue && lane_ok[1]) ? pos_q[1].base + toff_q : '0;
  assign bus.X_read_addr_2    = (issue && lane_ok[2]) ? pos_q[2].base + toff_q : '0;
  assign bus.X_read_addr_3    = (issue && lane_ok[3]) ? pos_q[3].base + toff_q : '0;
  assign bus.W_read_addr_0    = issue ? t_q : '0;
  assign bus.W_read_addr_1    = issue ? t_q : '0;
  assign bus.W_read_addr_2    = issue ? t_q : '0;
  assign bus.W_read_addr_3    = issue ? t_q : '0;
  assign bus.mac_en           = mac_en_q;
  assign bus.mac_first        = mac_first_q;
  assign bus.mac_last         = mac_last_q;
  assign bus.lane_valid       = lane_valid_q;
  assign bus.compute_finished = (state_q == S_DONE);
endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: records a per-cycle trace of each run and compares it
// against hand-derived cycle counts, addresses and strobe counts.
module tb_conv_sched;
  localparam int R     = 15;
  localparam int C     = 13;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_sched_if #(.R(R), .C(C), .MAXK(7))  sif ();
  conv_sched_if #(.R(R), .C(C), .MAXK(15)) bif ();

  conv_sched #(.R(R), .C(C), .MAXK(7))  dut     (.clk(clk), .reset(reset), .bus(sif.master));
  conv_sched #(.R(R), .C(C), .MAXK(15)) dut_big (.clk(clk), .reset(reset), .bus(bif.master));

  int         tr_x [4][DEPTH];
  int         tr_w [DEPTH];
  logic       tr_en [DEPTH];
  logic       tr_first [DEPTH];
  logic       tr_last [DEPTH];
  logic       tr_fin [DEPTH];
  logic [3:0] tr_lv [DEPTH];

  int         st_fin, st_en, st_first, st_last, st_pulses, st_bad;
  logic [3:0] st_lv_last;
  int         errors = 0;
  int         checks = 0;

  // Cycle 0 is the first IDLE cycle with inputs_loaded high; a cycle with inputs_loaded low precedes it to arm the block.
  task automatic run(input int k, input bit big, input int stall_at, input int stall_len, input int reset_at);
    int kk;
    kk = k * k;
    st_fin = -1; st_en = 0; st_first = 0; st_last = 0; st_pulses = 0; st_bad = 0; st_lv_last = '0;
    @(negedge clk);
    reset = 1'b0;
    sif.inputs_loaded = 1'b0; bif.inputs_loaded = 1'b0;
    sif.K = 3'(k); bif.K = 4'(k);
    sif.out_ready = 1'b1; bif.out_ready = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clk);
      reset = (c == reset_at);
      sif.inputs_loaded = !big;
      bif.inputs_loaded = big;
      sif.out_ready = !(c >= stall_at && c < stall_at + stall_len);
      bif.out_ready = sif.out_ready;
      #1;
      if (big) begin
        tr_x[0][c] = int'(bif.X_read_addr_0); tr_x[1][c] = int'(bif.X_read_addr_1);
        tr_x[2][c] = int'(bif.X_read_addr_2); tr_x[3][c] = int'(bif.X_read_addr_3);
        tr_w[c] = int'(bif.W_read_addr_0);
        tr_en[c] = bif.mac_en; tr_first[c] = bif.mac_first; tr_last[c] = bif.mac_last;
        tr_lv[c] = bif.lane_valid; tr_fin[c] = bif.compute_finished;
        if (bif.W_read_addr_1 !== bif.W_read_addr_0 || bif.W_read_addr_2 !== bif.W_read_addr_0 ||
            bif.W_read_addr_3 !== bif.W_read_addr_0) st_bad++;
      end else begin
        tr_x[0][c] = int'(sif.X_read_addr_0); tr_x[1][c] = int'(sif.X_read_addr_1);
        tr_x[2][c] = int'(sif.X_read_addr_2); tr_x[3][c] = int'(sif.X_read_addr_3);
        tr_w[c] = int'(sif.W_read_addr_0);
        tr_en[c] = sif.mac_en; tr_first[c] = sif.mac_first; tr_last[c] = sif.mac_last;
        tr_lv[c] = sif.lane_valid; tr_fin[c] = sif.compute_finished;
        if (sif.W_read_addr_1 !== sif.W_read_addr_0 || sif.W_read_addr_2 !== sif.W_read_addr_0 ||
            sif.W_read_addr_3 !== sif.W_read_addr_0) st_bad++;
      end
      if (tr_en[c] === 1'b1) st_en++;
      if (tr_first[c] === 1'b1) st_first++;
      if (tr_last[c] === 1'b1) begin st_last++; st_lv_last = tr_lv[c]; end
      if (tr_fin[c] === 1'b1) begin st_pulses++; if (st_fin < 0) st_fin = c; end
      // Addresses of cycle c-1 are judged by the strobes registered from them, visible in cycle c.
      if (c > 0 && tr_en[c] === 1'b1) begin
        for (int i = 0; i < 4; i++) begin
          if (tr_lv[c][i] ? (tr_x[i][c-1] >= R * C) : (tr_x[i][c-1] != 0)) st_bad++;
        end
        if (tr_w[c-1] >= kk) st_bad++;
      end
      if (st_fin >= 0 && c >= st_fin + 4) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sif.inputs_loaded = 1'b0; bif.inputs_loaded = 1'b0;
    sif.K = '0; bif.K = '0; sif.out_ready = 1'b1; bif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sif.compute_finished !== 1'b0) begin errors++; $display("FAIL rst_finished: got %b want 0", sif.compute_finished); end
    checks++; if ({sif.mac_en, sif.mac_first, sif.mac_last} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {sif.mac_en, sif.mac_first, sif.mac_last}); end
    checks++; if (sif.lane_valid !== 4'b0000) begin errors++; $display("FAIL rst_lane_valid: got %b want 0000", sif.lane_valid); end
    checks++; if ({sif.X_read_addr_0, sif.X_read_addr_1, sif.X_read_addr_2, sif.X_read_addr_3} !== 32'h0) begin errors++; $display("FAIL rst_x_addr: got %h want 0", {sif.X_read_addr_0, sif.X_read_addr_1, sif.X_read_addr_2, sif.X_read_addr_3}); end
    checks++; if (sif.W_read_addr_0 !== 6'd0) begin errors++; $display("FAIL rst_w_addr: got %0d want 0", sif.W_read_addr_0); end
  endtask

  task automatic test_k3();
    int exp_x1 [9] = '{1, 2, 3, 14, 15, 16, 27, 28, 29};
    run(3, 1'b0, -1, 0, -1);
    checks++; if (st_fin !== 327) begin errors++; $display("FAIL k3_finish_cycle: got %0d want 327", st_fin); end
    checks++; if (st_pulses !== 1) begin errors++; $display("FAIL k3_finish_pulses: got %0d want 1", st_pulses); end
    checks++; if (st_en !== 324) begin errors++; $display("FAIL k3_mac_en_count: got %0d want 324", st_en); end
    checks++; if (st_first !== 36) begin errors++; $display("FAIL k3_mac_first_count: got %0d want 36", st_first); end
    checks++; if (st_last !== 36) begin errors++; $display("FAIL k3_mac_last_count: got %0d want 36", st_last); end
    checks++; if (st_lv_last !== 4'b0111) begin errors++; $display("FAIL k3_final_lane_valid: got %b want 0111", st_lv_last); end
    checks++; if (st_bad !== 0) begin errors++; $display("FAIL k3_addr_rules: got %0d violations want 0", st_bad); end
    for (int t = 0; t < 9; t++) begin
      checks++; if (tr_x[1][2+t] !== exp_x1[t] || tr_w[2+t] !== t) begin
        errors++; $display("FAIL k3_g0_lane1_tap%0d: got x=%0d w=%0d want x=%0d w=%0d", t, tr_x[1][2+t], tr_w[2+t], exp_x1[t], t);
      end
    end
    checks++; if ({tr_first[3], tr_last[3], tr_first[11], tr_last[11]} !== 4'b1001) begin
      errors++; $display("FAIL k3_first_last_align: got %b want 1001", {tr_first[3], tr_last[3], tr_first[11], tr_last[11]});
    end
    checks++; if (tr_x[1][st_fin+3] !== 0 || tr_en[st_fin+4] !== 1'b0) begin
      errors++; $display("FAIL k3_no_rearm: got x1=%0d en=%b want 0 0", tr_x[1][st_fin+3], tr_en[st_fin+4]);
    end
  endtask

  task automatic test_k1();
    int mism, bad_addr;
    run(1, 1'b0, -1, 0, -1);
    mism = 0; bad_addr = 0;
    for (int c = 0; c <= st_fin; c++) if (tr_en[c] !== tr_first[c] || tr_en[c] !== tr_last[c]) mism++;
    for (int c = 2; c <= 50; c++)
      for (int i = 0; i < 4; i++)
        if (tr_lv[c+1][i] === 1'b1 && tr_x[i][c] !== 4 * (c - 2) + i) bad_addr++;
    checks++; if (st_fin !== 52) begin errors++; $display("FAIL k1_finish_cycle: got %0d want 52", st_fin); end
    checks++; if (st_en !== 49) begin errors++; $display("FAIL k1_mac_en_count: got %0d want 49", st_en); end
    checks++; if (mism !== 0) begin errors++; $display("FAIL k1_first_last_every_cycle: got %0d mismatching cycles want 0", mism); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL k1_lane_addr: got %0d wrong addresses want 0", bad_addr); end
    checks++; if (st_lv_last !== 4'b0111) begin errors++; $display("FAIL k1_final_lane_valid: got %b want 0111", st_lv_last); end
    checks++; if (st_bad !== 0) begin errors++; $display("FAIL k1_addr_rules: got %0d violations want 0", st_bad); end
  endtask

  task automatic test_k7();
    run(7, 1'b0, -1, 0, -1);
    checks++; if (st_fin !== 787) begin errors++; $display("FAIL k7_finish_cycle: got %0d want 787", st_fin); end
    checks++; if (st_en !== 784) begin errors++; $display("FAIL k7_mac_en_count: got %0d want 784", st_en); end
    checks++; if (tr_x[0][51] !== 4 || tr_x[1][51] !== 5 || tr_x[2][51] !== 6 || tr_x[3][51] !== 13) begin
      errors++; $display("FAIL k7_g1_tap0: got %0d %0d %0d %0d want 4 5 6 13", tr_x[0][51], tr_x[1][51], tr_x[2][51], tr_x[3][51]);
    end
    checks++; if (tr_x[0][50] !== 84 || tr_w[50] !== 48) begin
      errors++; $display("FAIL k7_g0_last_tap: got x0=%0d w=%0d want 84 48", tr_x[0][50], tr_w[50]);
    end
    checks++; if (st_bad !== 0) begin errors++; $display("FAIL k7_addr_rules: got %0d violations want 0", st_bad); end
  endtask

  task automatic test_invalid_k();
    int nz;
    for (int v = 0; v < 2; v++) begin
      run(v == 0 ? 0 : 14, v == 1, -1, 0, -1);
      nz = 0;
      for (int c = 0; c <= st_fin + 4; c++)
        if (tr_x[0][c] != 0 || tr_x[1][c] != 0 || tr_x[2][c] != 0 || tr_x[3][c] != 0 || tr_w[c] != 0) nz++;
      checks++; if (st_fin !== 2) begin errors++; $display("FAIL invalid_k%0d_finish_cycle: got %0d want 2", v == 0 ? 0 : 14, st_fin); end
      checks++; if (st_en !== 0 || nz !== 0) begin
        errors++; $display("FAIL invalid_k%0d_idle_outputs: got mac_en=%0d nonzero_addr=%0d want 0 0", v == 0 ? 0 : 14, st_en, nz);
      end
    end
  endtask

  task automatic test_stall();
    int en_stall, addr_stall;
    run(3, 1'b0, 20, 5, -1);
    en_stall = 0; addr_stall = 0;
    for (int c = 21; c <= 25; c++) if (tr_en[c] !== 1'b0) en_stall++;
    for (int c = 20; c <= 24; c++) if (tr_x[0][c] != 0 || tr_x[1][c] != 0 || tr_w[c] != 0) addr_stall++;
    checks++; if (st_fin !== 332) begin errors++; $display("FAIL stall_finish_cycle: got %0d want 332", st_fin); end
    checks++; if (st_en !== 324) begin errors++; $display("FAIL stall_mac_en_count: got %0d want 324", st_en); end
    checks++; if (en_stall !== 0 || addr_stall !== 0) begin
      errors++; $display("FAIL stall_no_issue: got en=%0d addr=%0d active cycles want 0 0", en_stall, addr_stall);
    end
    checks++; if (tr_en[20] !== 1'b1 || tr_last[20] !== 1'b1) begin
      errors++; $display("FAIL stall_prev_last_strobe: got en=%b last=%b want 1 1", tr_en[20], tr_last[20]);
    end
    checks++; if (tr_x[0][25] !== 8 || tr_first[26] !== 1'b1) begin
      errors++; $display("FAIL stall_resume: got x0=%0d first=%b want 8 1", tr_x[0][25], tr_first[26]);
    end
  endtask

  task automatic test_reset_mid_issue();
    run(3, 1'b0, -1, 0, 30);
    checks++; if ({tr_en[31], tr_first[31], tr_last[31], tr_fin[31]} !== 4'b0000 || tr_lv[31] !== 4'b0000) begin
      errors++; $display("FAIL midrst_outputs: got en/first/last/fin=%b lv=%b want 0000 0000",
                         {tr_en[31], tr_first[31], tr_last[31], tr_fin[31]}, tr_lv[31]);
    end
    checks++; if (tr_x[0][31] != 0 || tr_x[1][31] != 0 || tr_x[2][31] != 0 || tr_x[3][31] != 0 || tr_w[31] != 0) begin
      errors++; $display("FAIL midrst_addr: got %0d %0d %0d %0d w=%0d want all 0", tr_x[0][31], tr_x[1][31], tr_x[2][31], tr_x[3][31], tr_w[31]);
    end
    checks++; if (st_fin !== 358 || st_pulses !== 1) begin
      errors++; $display("FAIL midrst_finish: got cycle=%0d pulses=%0d want 358 1", st_fin, st_pulses);
    end
    checks++; if (tr_x[1][33] !== 1 || tr_w[33] !== 0 || tr_first[34] !== 1'b1) begin
      errors++; $display("FAIL midrst_restart_g0: got x1=%0d w=%0d first=%b want 1 0 1", tr_x[1][33], tr_w[33], tr_first[34]);
    end
    checks++; if (st_en !== 352) begin errors++; $display("FAIL midrst_mac_en_count: got %0d want 352", st_en); end
  endtask

  initial begin
    test_reset();
    test_k3();
    test_k1();
    test_k7();
    test_invalid_k();
    test_stall();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
